// File: rtl/fetch_byte_sequencer_pkg.sv
// Shared types and constants for the byte-serial fetch/decode sequencer.
//   ADDR_W / IMM_W : PC width and displacement/immediate register width
//   MAX_LEN        : architectural maximum instruction length in bytes
//   phase_e        : sequencer phase, also exported as cur_obj
package fetch_byte_sequencer_pkg;

  localparam int unsigned ADDR_W          = 64;
  localparam int unsigned IMM_W           = 64;
  localparam int unsigned MAX_LEN         = 15;
  localparam int unsigned LEN_W           = 4;
  localparam int unsigned SIZE_W          = 4;
  localparam int unsigned MAX_CONST_BYTES = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IMM_W-1:0]  imm_t;

  // HEADER shares encoding 0 with the fstate OPCODE_1 object.
  typedef enum logic [1:0] {
    PH_HEADER = 2'd0,
    PH_DISP   = 2'd1,
    PH_IMM    = 2'd2,
    PH_ISSUE  = 2'd3
  } phase_e;

  localparam phase_e PH_OPCODE_1 = PH_HEADER;

endpackage

// File: rtl/fetch_byte_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours (fetch buffer,
// header decoder, issue stage).
//   master : sequencer side (drives fb_ready, hdr_active, inst_*, cur_obj)
//   slave  : environment side (drives flush, fb_*, hdr_*, inst_ready)
interface fetch_byte_sequencer_if;
  import fetch_byte_sequencer_pkg::*;

  logic              flush;
  logic [7:0]        fb_byte;
  addr_t             fb_pc;
  logic              fb_valid;
  logic              fb_ready;
  logic              hdr_active;
  logic              hdr_done;
  logic [SIZE_W-1:0] hdr_disp_size;
  logic [SIZE_W-1:0] hdr_imm_size;
  logic              inst_valid;
  logic              inst_ready;
  addr_t             inst_pc;
  logic [LEN_W-1:0]  inst_len;
  imm_t              inst_disp;
  imm_t              inst_imm;
  logic              inst_fault;
  logic [1:0]        cur_obj;

  modport master (
    input  flush, fb_byte, fb_pc, fb_valid, hdr_done, hdr_disp_size,
           hdr_imm_size, inst_ready,
    output fb_ready, hdr_active, inst_valid, inst_pc, inst_len, inst_disp,
           inst_imm, inst_fault, cur_obj
  );

  modport slave (
    output flush, fb_byte, fb_pc, fb_valid, hdr_done, hdr_disp_size,
           hdr_imm_size, inst_ready,
    input  fb_ready, hdr_active, inst_valid, inst_pc, inst_len, inst_disp,
           inst_imm, inst_fault, cur_obj
  );

endinterface

// File: rtl/fetch_byte_sequencer_const_collector.sv
// Byte counter plus little-endian accumulator with running sign extension,
// used for both the displacement and the immediate.
//   clear     : zero size, count and value (highest priority)
//   load      : latch expected byte count, restart counter
//   strobe    : accept byte_in as byte number cnt
//   size_o    : latched byte count
//   last_c    : the byte at the current count is the final one
//   value_o   : accumulated, sign-extended value
module fetch_const_collector
  import fetch_byte_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [SIZE_W-1:0] load_size,
  input  logic              strobe,
  input  logic [7:0]        byte_in,
  output logic [SIZE_W-1:0] size_o,
  output logic              last_c,
  output imm_t              value_o
);

  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  imm_t              value_q, value_d;
  logic [5:0]        shamt;
  imm_t              sext;
  imm_t              keep_mask;

  // Byte k replaces everything from bit 8k upward with the sign-extended
  // byte, so the final value is sign-extended from the last byte received.
  always_comb begin
    shamt     = {cnt_q[2:0], 3'b000};
    sext      = {{(IMM_W-8){byte_in[7]}}, byte_in};
    keep_mask = ~(~imm_t'(0) << shamt);
    size_d    = size_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    if (clear) begin
      size_d  = '0;
      cnt_d   = '0;
      value_d = '0;
    end else if (load) begin
      size_d = load_size;
      cnt_d  = '0;
    end else if (strobe) begin
      value_d = (value_q & keep_mask) | (sext << shamt);
      cnt_d   = cnt_q + SIZE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign last_c  = (cnt_q + SIZE_W'(1)) == size_q;
  assign size_o  = size_q;
  assign value_o = value_q;

endmodule

// File: rtl/fetch_byte_sequencer.sv
// Byte-serial x86-64 fetch/decode sequencer: walks HEADER -> DISPLACEMENT ->
// IMMEDIATE -> ISSUE, counts instruction length, captures the start PC and
// hands one assembled instruction to the issue stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : master side of fetch_byte_sequencer_if (fetch buffer byte
//              handshake, header decoder sizes, issue handshake, cur_obj)
module fetch_byte_sequencer
  import fetch_byte_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  fetch_byte_sequencer_if.master bus
);

  phase_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  addr_t            pc_q, pc_d;
  logic             fault_q, fault_d;

  logic              accept;
  logic              clear_c;
  logic              load_c;
  logic              disp_strobe_c;
  logic              imm_strobe_c;
  logic              disp_last_c;
  logic              imm_last_c;
  logic [SIZE_W-1:0] disp_size;
  logic [SIZE_W-1:0] imm_size;
  imm_t              disp_value;
  imm_t              imm_value;

  assign bus.fb_ready = !rst && !bus.flush && (state_q != PH_ISSUE);
  assign accept       = bus.fb_valid && bus.fb_ready;

  // Next-state, length and PC; flush outranks everything, then the issue
  // handshake, then byte acceptance.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    clear_c       = 1'b0;
    load_c        = 1'b0;
    disp_strobe_c = 1'b0;
    imm_strobe_c  = 1'b0;
    if (bus.flush) begin
      state_d = PH_HEADER;
      len_d   = '0;
      pc_d    = '0;
      fault_d = 1'b0;
      clear_c = 1'b1;
    end else if (state_q == PH_ISSUE) begin
      if (bus.inst_ready) begin
        state_d = PH_HEADER;
        len_d   = '0;
        fault_d = 1'b0;
        clear_c = 1'b1;
      end
    end else if (accept) begin
      len_d = len_q + LEN_W'(1);
      if (len_q == '0) begin
        pc_d = bus.fb_pc;
      end
      unique case (state_q)
        PH_HEADER: begin
          if (bus.hdr_done) begin
            load_c = 1'b1;
            if ((bus.hdr_disp_size > SIZE_W'(MAX_CONST_BYTES)) ||
                (bus.hdr_imm_size > SIZE_W'(MAX_CONST_BYTES))) begin
              fault_d = 1'b1;
              state_d = PH_ISSUE;
            end else if (bus.hdr_disp_size != '0) begin
              state_d = PH_DISP;
            end else if (bus.hdr_imm_size != '0) begin
              state_d = PH_IMM;
            end else begin
              state_d = PH_ISSUE;
            end
          end
        end
        PH_DISP: begin
          disp_strobe_c = (disp_size != '0);
          if (disp_last_c) begin
            state_d = (imm_size != '0) ? PH_IMM : PH_ISSUE;
          end
        end
        PH_IMM: begin
          imm_strobe_c = 1'b1;
          if (imm_last_c) begin
            state_d = PH_ISSUE;
          end
        end
        default: ;
      endcase
      // Hitting the length limit without finishing ends the instruction.
      if ((len_d == LEN_W'(MAX_LEN)) && (state_d != PH_ISSUE)) begin
        fault_d = 1'b1;
        state_d = PH_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PH_HEADER;
      len_q   <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_const_collector u_disp (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_c),
    .load      (load_c),
    .load_size (bus.hdr_disp_size),
    .strobe    (disp_strobe_c),
    .byte_in   (bus.fb_byte),
    .size_o    (disp_size),
    .last_c    (disp_last_c),
    .value_o   (disp_value)
  );

  fetch_const_collector u_imm (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_c),
    .load      (load_c),
    .load_size (bus.hdr_imm_size),
    .strobe    (imm_strobe_c),
    .byte_in   (bus.fb_byte),
    .size_o    (imm_size),
    .last_c    (imm_last_c),
    .value_o   (imm_value)
  );

  assign bus.hdr_active = (state_q == PH_HEADER);
  assign bus.inst_valid = (state_q == PH_ISSUE);
  assign bus.inst_pc    = pc_q;
  assign bus.inst_len   = len_q;
  assign bus.inst_disp  = disp_value;
  assign bus.inst_imm   = imm_value;
  assign bus.inst_fault = fault_q;
  assign bus.cur_obj    = state_q;

endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// Self-checking bench for fetch_byte_sequencer: directed scenarios plus
// randomized instructions checked against a byte-stream reference model.
module tb_fetch_byte_sequencer;

  logic clk = 1'b0;
  logic rst;

  fetch_byte_sequencer_if bus();

  fetch_byte_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit gap_en   = 1'b0;

  logic [7:0] stream [24];

  // Little-endian value of n bytes starting at stream[start], sign-extended
  // from the top byte.
  function automatic logic [63:0] sext_le(input int start, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int j = 0; j < n; j++) v = v | (64'(stream[start+j]) << (8*j));
    if (n > 0 && n < 8 && stream[start+n-1][7]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic [63:0] pc,
                            input logic done, input logic [3:0] ds,
                            input logic [3:0] isz);
    if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.fb_valid      = 1'b1;
    bus.fb_byte       = b;
    bus.fb_pc         = pc;
    bus.hdr_done      = done;
    bus.hdr_disp_size = ds;
    bus.hdr_imm_size  = isz;
    @(posedge clk);
    #1;
    bus.fb_valid = 1'b0;
    bus.hdr_done = 1'b0;
  endtask

  task automatic issue_ack(input int stall);
    repeat (stall) @(negedge clk);
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.fb_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.fb_ready !== 1'b0) $display("FAIL reset_fb_ready got %b want 0", bus.fb_ready); else n_pass++;
    n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.inst_valid); else n_pass++;
    n_checks++; if (bus.inst_len !== 4'd0) $display("FAIL reset_len got %0d want 0", bus.inst_len); else n_pass++;
    n_checks++; if (bus.inst_pc !== 64'd0) $display("FAIL reset_pc got %h want 0", bus.inst_pc); else n_pass++;
    n_checks++; if (bus.inst_disp !== 64'd0 || bus.inst_imm !== 64'd0) $display("FAIL reset_consts got %h/%h want 0/0", bus.inst_disp, bus.inst_imm); else n_pass++;
    n_checks++; if (bus.inst_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", bus.inst_fault); else n_pass++;
    n_checks++; if (bus.cur_obj !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.cur_obj); else n_pass++;
    rst          = 1'b0;
    bus.fb_valid = 1'b0;
    #1;
    n_checks++; if (bus.fb_ready !== 1'b1) $display("FAIL post_reset_fb_ready got %b want 1", bus.fb_ready); else n_pass++;
  endtask

  task automatic test_disp8_imm32();
    drive_byte(8'h8B, 64'h1000, 1'b0, 4'd0, 4'd0);
    drive_byte(8'h05, 64'h1001, 1'b1, 4'd1, 4'd4);
    drive_byte(8'hF0, 64'h1002, 1'b0, 4'd0, 4'd0);
    drive_byte(8'h78, 64'h1003, 1'b0, 4'd0, 4'd0);
    drive_byte(8'h56, 64'h1004, 1'b0, 4'd0, 4'd0);
    drive_byte(8'h34, 64'h1005, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL d8i32_early_valid got %b want 0", bus.inst_valid); else n_pass++;
    drive_byte(8'h12, 64'h1006, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1) $display("FAIL d8i32_valid got %b want 1", bus.inst_valid); else n_pass++;
    n_checks++; if (bus.inst_pc !== 64'h1000) $display("FAIL d8i32_pc got %h want 1000", bus.inst_pc); else n_pass++;
    n_checks++; if (bus.inst_len !== 4'd7) $display("FAIL d8i32_len got %0d want 7", bus.inst_len); else n_pass++;
    n_checks++; if (bus.inst_disp !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL d8i32_disp got %h want fffffffffffffff0", bus.inst_disp); else n_pass++;
    n_checks++; if (bus.inst_imm !== 64'h0000_0000_1234_5678) $display("FAIL d8i32_imm got %h want 12345678", bus.inst_imm); else n_pass++;
    n_checks++; if (bus.inst_fault !== 1'b0) $display("FAIL d8i32_fault got %b want 0", bus.inst_fault); else n_pass++;
    issue_ack(0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL d8i32_drop_valid got %b want 0", bus.inst_valid); else n_pass++;
  endtask

  task automatic test_disp32_imm64();
    logic [7:0] d [4];
    d = '{8'h00, 8'h00, 8'h00, 8'h80};
    drive_byte(8'h8B, 64'h2000, 1'b1, 4'd4, 4'd8);
    for (int i = 0; i < 4; i++) drive_byte(d[i], 64'h2001 + 64'(i), 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) drive_byte(8'(i + 1), 64'h2005 + 64'(i), 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_disp !== 64'hFFFF_FFFF_8000_0000) $display("FAIL d32i64_disp got %h want ffffffff80000000", bus.inst_disp); else n_pass++;
    n_checks++; if (bus.inst_imm !== 64'h0807_0605_0403_0201) $display("FAIL d32i64_imm got %h want 0807060504030201", bus.inst_imm); else n_pass++;
    n_checks++; if (bus.inst_len !== 4'd13) $display("FAIL d32i64_len got %0d want 13", bus.inst_len); else n_pass++;
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b0) $display("FAIL d32i64_valid_fault got %b%b want 10", bus.inst_valid, bus.inst_fault); else n_pass++;
    issue_ack(1);
  endtask

  task automatic test_issue_stall();
    drive_byte(8'hC3, 64'h3000, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_len !== 4'd1) $display("FAIL stall_hdr_only got valid=%b len=%0d want 1/1", bus.inst_valid, bus.inst_len); else n_pass++;
    bus.fb_valid = 1'b1;
    bus.fb_byte  = 8'h90;
    bus.fb_pc    = 64'h3001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h3000 || bus.inst_len !== 4'd1) $display("FAIL stall_hold_%0d got valid=%b pc=%h len=%0d want 1/3000/1", i, bus.inst_valid, bus.inst_pc, bus.inst_len); else n_pass++;
      n_checks++; if (bus.fb_ready !== 1'b0) $display("FAIL stall_fb_ready_%0d got %b want 0", i, bus.fb_ready); else n_pass++;
    end
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.fb_ready !== 1'b1 || bus.hdr_active !== 1'b1) $display("FAIL stall_release got valid=%b ready=%b hdr=%b want 0/1/1", bus.inst_valid, bus.fb_ready, bus.hdr_active); else n_pass++;
    @(posedge clk);
    #1;
    bus.fb_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.inst_len !== 4'd1 || bus.inst_pc !== 64'h3001) $display("FAIL stall_next_byte got len=%0d pc=%h want 1/3001", bus.inst_len, bus.inst_pc); else n_pass++;
    drive_byte(8'hC3, 64'h3002, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_len !== 4'd2 || bus.inst_valid !== 1'b1) $display("FAIL stall_second_inst got len=%0d valid=%b want 2/1", bus.inst_len, bus.inst_valid); else n_pass++;
    issue_ack(0);
  endtask

  task automatic test_flush();
    drive_byte(8'h68, 64'h4000, 1'b1, 4'd0, 4'd4);
    drive_byte(8'h11, 64'h4001, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    bus.fb_valid = 1'b1;
    bus.fb_byte  = 8'h22;
    bus.fb_pc    = 64'h4002;
    bus.flush    = 1'b1;
    #1;
    n_checks++; if (bus.fb_ready !== 1'b0) $display("FAIL flush_fb_ready got %b want 0", bus.fb_ready); else n_pass++;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.fb_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.cur_obj !== 2'd0) $display("FAIL flush_state got valid=%b obj=%0d want 0/0", bus.inst_valid, bus.cur_obj); else n_pass++;
    n_checks++; if (bus.inst_len !== 4'd0 || bus.inst_imm !== 64'd0) $display("FAIL flush_cleared got len=%0d imm=%h want 0/0", bus.inst_len, bus.inst_imm); else n_pass++;
    drive_byte(8'hC3, 64'h5000, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_pc !== 64'h5000 || bus.inst_len !== 4'd1) $display("FAIL flush_next_pc got pc=%h len=%0d want 5000/1", bus.inst_pc, bus.inst_len); else n_pass++;
    bus.inst_ready = 1'b1;
    bus.flush      = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
    bus.flush      = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.inst_len !== 4'd0 || bus.inst_pc !== 64'd0) $display("FAIL flush_with_ready got valid=%b len=%0d pc=%h want 0/0/0", bus.inst_valid, bus.inst_len, bus.inst_pc); else n_pass++;
  endtask

  task automatic test_len_limit();
    for (int i = 0; i < 15; i++) drive_byte(8'h66, 64'h6000 + 64'(i), 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1 || bus.inst_len !== 4'd15) $display("FAIL len15_nodone got valid=%b fault=%b len=%0d want 1/1/15", bus.inst_valid, bus.inst_fault, bus.inst_len); else n_pass++;
    issue_ack(0);
    for (int i = 0; i < 15; i++) drive_byte(8'h66, 64'h6100 + 64'(i), (i == 14), 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b0 || bus.inst_len !== 4'd15) $display("FAIL len15_exact got valid=%b fault=%b len=%0d want 1/0/15", bus.inst_valid, bus.inst_fault, bus.inst_len); else n_pass++;
    issue_ack(0);
    drive_byte(8'h8B, 64'h7000, 1'b1, 4'd9, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1 || bus.inst_len !== 4'd1) $display("FAIL size9_fault got valid=%b fault=%b len=%0d want 1/1/1", bus.inst_valid, bus.inst_fault, bus.inst_len); else n_pass++;
    issue_ack(0);
  endtask

  task automatic test_reset_mid();
    gap_en = 1'b1;
    drive_byte(8'h8B, 64'h8000, 1'b1, 4'd4, 4'd0);
    drive_byte(8'hAA, 64'h8001, 1'b0, 4'd0, 4'd0);
    drive_byte(8'hBB, 64'h8002, 1'b0, 4'd0, 4'd0);
    gap_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.inst_len !== 4'd0 || bus.inst_pc !== 64'd0 || bus.inst_disp !== 64'd0) $display("FAIL async_rst_regs got len=%0d pc=%h disp=%h want 0/0/0", bus.inst_len, bus.inst_pc, bus.inst_disp); else n_pass++;
    n_checks++; if (bus.fb_ready !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst_fault !== 1'b0 || bus.cur_obj !== 2'd0) $display("FAIL async_rst_ctl got rdy=%b valid=%b fault=%b obj=%0d want 0/0/0/0", bus.fb_ready, bus.inst_valid, bus.inst_fault, bus.cur_obj); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drive_byte(8'hC3, 64'h9000, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h9000 || bus.inst_len !== 4'd1 || bus.inst_disp !== 64'd0) $display("FAIL after_rst_inst got valid=%b pc=%h len=%0d disp=%h want 1/9000/1/0", bus.inst_valid, bus.inst_pc, bus.inst_len, bus.inst_disp); else n_pass++;
    issue_ack(0);
  endtask

  task automatic test_random();
    int hlen, ds, isz, consumed, nd, ni;
    bit done_g, efault;
    logic [63:0] pc0, exp_disp, exp_imm;
    gap_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      done_g = ($urandom_range(0, 9) != 0);
      hlen   = $urandom_range(1, 5);
      ds     = ($urandom_range(0, 15) == 0) ? 9 + $urandom_range(0, 6) : $urandom_range(0, 8);
      isz    = ($urandom_range(0, 15) == 0) ? 9 + $urandom_range(0, 6) : $urandom_range(0, 8);
      pc0    = {$urandom, $urandom};
      for (int i = 0; i < 24; i++) stream[i] = 8'($urandom);
      if (!done_g) begin
        hlen = 15; consumed = 15; efault = 1'b1;
      end else if (ds > 8 || isz > 8) begin
        consumed = hlen; efault = 1'b1;
      end else if (hlen + ds + isz > 15) begin
        consumed = 15; efault = 1'b1;
      end else begin
        consumed = hlen + ds + isz; efault = 1'b0;
      end
      nd = consumed - hlen;
      if (nd > ds) nd = ds;
      ni = consumed - hlen - ds;
      if (ni < 0) ni = 0;
      exp_disp = sext_le(hlen, nd);
      exp_imm  = sext_le(hlen + ds, ni);
      for (int i = 0; i < consumed; i++)
        drive_byte(stream[i], pc0 + 64'(i), done_g && (i == hlen - 1), 4'(ds), 4'(isz));
      @(negedge clk);
      n_checks++; if (bus.inst_valid !== 1'b1) $display("FAIL rnd%0d_valid got %b want 1", k, bus.inst_valid); else n_pass++;
      n_checks++; if (bus.inst_pc !== pc0) $display("FAIL rnd%0d_pc got %h want %h", k, bus.inst_pc, pc0); else n_pass++;
      n_checks++; if (bus.inst_len !== 4'(consumed)) $display("FAIL rnd%0d_len got %0d want %0d", k, bus.inst_len, consumed); else n_pass++;
      n_checks++; if (bus.inst_fault !== efault) $display("FAIL rnd%0d_fault got %b want %b", k, bus.inst_fault, efault); else n_pass++;
      n_checks++; if (bus.inst_disp !== exp_disp) $display("FAIL rnd%0d_disp got %h want %h", k, bus.inst_disp, exp_disp); else n_pass++;
      n_checks++; if (bus.inst_imm !== exp_imm) $display("FAIL rnd%0d_imm got %h want %h", k, bus.inst_imm, exp_imm); else n_pass++;
      issue_ack($urandom_range(0, 3));
      @(negedge clk);
      n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL rnd%0d_release got %b want 0", k, bus.inst_valid); else n_pass++;
    end
    gap_en = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.fb_byte       = 8'h00;
    bus.fb_pc         = 64'd0;
    bus.fb_valid      = 1'b0;
    bus.hdr_done      = 1'b0;
    bus.hdr_disp_size = 4'd0;
    bus.hdr_imm_size  = 4'd0;
    bus.inst_ready    = 1'b0;
    test_reset();
    test_disp8_imm32();
    test_disp32_imm64();
    test_issue_stall();
    test_flush();
    test_len_limit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_byte_sequencer.md
Name: fetch_byte_sequencer

Overview:
Sequences the byte-serial x86-64 fetch/decode front end.
- Owns the phase state machine (HEADER / DISPLACEMENT / IMMEDIATE / ISSUE).
- Owns the byte handshake with the fetch buffer and the displacement and immediate byte counters.
- Accumulates the displacement and immediate bytes little-endian with running sign extension, then presents one assembled instruction to the micro-instruction issue stage.
- The header decoder (prefix/REX/opcode/ModRM/SIB) runs in HEADER and reports the constant sizes.

Parameters:
- ADDR_W, 64, width of the PC.
- IMM_W, 64, width of the disp/imm result registers.
- MAX_LEN, 15, architectural maximum instruction length in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  redirect; discards the in-flight instruction.
- fb_byte  in  8  instruction byte from the fetch buffer.
- fb_pc  in  ADDR_W  address of fb_byte.
- fb_valid  in  1  fb_byte/fb_pc valid.
- fb_ready  out  1  sequencer accepts a byte this cycle.
- hdr_active  out  1  state==HEADER; enables the header decoder.
- hdr_done  in  1  with an accepted byte: that byte ends the header.
- hdr_disp_size  in  4  displacement bytes (0..8), valid with hdr_done.
- hdr_imm_size  in  4  immediate bytes (0..8), valid with hdr_done.
- inst_valid  out  1  assembled instruction available.
- inst_ready  in  1  issue stage accepts it.
- inst_pc  out  ADDR_W  PC of the instruction's first byte.
- inst_len  out  4  total bytes consumed.
- inst_disp  out  IMM_W  sign-extended displacement.
- inst_imm  out  IMM_W  sign-extended immediate.
- inst_fault  out  1  length or size violation.
- cur_obj  out  2  current state, for debug and the phase modules.

Behaviour:
- Reset (async, rst=1):
  - State HEADER.
  - All registers zero: counters, len, pc, disp, imm, fault.
  - inst_valid=0, fb_ready=0 while rst is high.
- Handshake rules:
  - fb_ready = !rst && !flush && state!=ISSUE.
  - A byte is accepted when fb_valid && fb_ready.
  - No state change occurs without an accepted byte, except in ISSUE and on flush.
- len counting:
  - Increments on every accepted byte.
  - The first accepted byte of an instruction (len==0) latches inst_pc=fb_pc.
- HEADER state:
  - hdr_done is sampled only on an accepted byte; it then latches disp/imm sizes.
  - If either size exceeds 8, set fault and go to ISSUE.
  - Otherwise go to DISPLACEMENT if disp>0, else IMMEDIATE if imm>0, else ISSUE.
- DISPLACEMENT state (count c = 0..size-1):
  - Accepted byte k writes disp[IMM_W-1:8k] = sign-extend(byte).
  - Each later byte overwrites the upper bits, so the final value is sign-extended from the last byte.
  - When c+1==size, go to IMMEDIATE if imm>0, else ISSUE.
- IMMEDIATE state: same rule on the imm register; when c+1==size, go to ISSUE.
- ISSUE state:
  - inst_valid=1; all inst_* outputs held stable while inst_ready=0.
  - On inst_ready, go to HEADER next cycle and clear len, counters, disp, imm and fault.
- Latency: inst_valid rises the cycle after the final byte is accepted. A header-only instruction also takes 1 cycle.
- Length limit:
  - If an accepted byte makes len==MAX_LEN and that byte does not complete the instruction, set inst_fault=1 and go to ISSUE with len=MAX_LEN.
  - Completing exactly on byte MAX_LEN is legal (fault=0).
- Flush:
  - Synchronous and highest priority over all else, including the ISSUE handshake.
  - Next state HEADER, all registers cleared, inst_valid=0 next cycle.
  - The byte presented in the flush cycle is not accepted.
- Simultaneous inst_ready && flush: the instruction is considered dropped.
- fb_valid gaps: state and counters hold across the gap.

Decomposition:
- Shared package:
  - Phase enum (HEADER/OPCODE_1 naming consistent with the existing fstate obj encoding, DISPLACEMENT, IMMEDIATE, ISSUE).
  - addr_t, imm_t.
  - The MAX_LEN constant.
- Sub-module fetch_const_collector:
  - Holds the counter plus the sign-extending byte accumulator (load size, byte strobe, clear, done flag).
  - Instantiated twice, for disp and imm.
- The FSM, len and pc logic stay in the top module.

Test Plan:
- disp8+imm32: header bytes at pc 0x1000 (hdr_done on 2nd, disp=1, imm=4), then F0 78 56 34 12 -> inst_disp=0xFFFFFFFFFFFFFFF0, inst_imm=0x0000000012345678, inst_len=7, inst_pc=0x1000, inst_valid one cycle after the last byte.
- disp32 bytes 00 00 00 80 -> inst_disp=0xFFFFFFFF80000000; imm64 bytes 01..08 -> inst_imm=0x0807060504030201.
- inst_ready low 3 cycles in ISSUE -> inst_valid stays 1, outputs stable, fb_ready=0; on ready the next byte is accepted the following cycle.
- flush during the 2nd of 4 imm bytes -> HEADER next cycle, no inst_valid, next instruction's inst_pc equals the first post-flush byte's fb_pc.
- 15 header bytes with no hdr_done -> inst_fault=1, inst_len=15; hdr_disp_size=9 -> immediate fault.
- rst asserted mid-DISPLACEMENT with fb_valid gaps -> all outputs 0 asynchronously, HEADER after release.
